// File: rtl/instruction_fetch_stage_pkg.sv
// ============================================================================
// Module : instruction_fetch_stage_pkg
// Purpose: Shared definitions for the instruction fetch stage: FSM state
//          encodings, default reset PC and bubble encoding, and the
//          branch/jump redirect-target helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instruction_fetch_stage_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_RESET = 2'd0;
  localparam fetch_state_t S_REQ   = 2'd1;
  localparam fetch_state_t S_HOLD  = 2'd2;
  localparam fetch_state_t S_DRAIN = 2'd3;

  localparam logic [31:0] c_reset_pc_default  = 32'h0000_0000;
  localparam logic [31:0] c_nop_instr_default = 32'h0000_0000;  // sll $0,$0,0

  // Branch wins over jump. Jumps stay inside the 256 MB region of the
  // instruction currently in IF/ID. The target is always word aligned.
  function automatic logic [31:0] redirect_target(
    input logic        pcsrc,
    input logic [31:0] branch_target,
    input logic [25:0] jump_index,
    input logic [3:0]  pcplus4_hi
  );
    logic [31:0] t;
    t      = pcsrc ? branch_target : {pcplus4_hi, jump_index, 2'b00};
    t[1:0] = 2'b00;
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_stage_if.sv
// ============================================================================
// Module : instruction_fetch_stage_if
// Purpose: Bundles the fetch stage's pipeline control, instruction memory
//          handshake and IF/ID outputs.
// Ports  : stall, pcsrc, branch_target, jump, jump_index   (control in)
//          imem_req, imem_addr / imem_ready, imem_data     (memory)
//          if_id_instruction, if_id_pcplus4, if_id_valid, pc (out)
//          modport master = fetch stage, slave = its environment
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_stage_if;
  logic        stall;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pcplus4;
  logic        if_id_valid;
  logic [31:0] pc;

  modport master (
    input  stall, pcsrc, branch_target, jump, jump_index, imem_ready, imem_data,
    output imem_req, imem_addr, if_id_instruction, if_id_pcplus4, if_id_valid, pc
  );

  modport slave (
    output stall, pcsrc, branch_target, jump, jump_index, imem_ready, imem_data,
    input  imem_req, imem_addr, if_id_instruction, if_id_pcplus4, if_id_valid, pc
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_stage_skid_buffer.sv
// ============================================================================
// Module : fetch_skid_buffer
// Purpose: One-entry data+valid register that parks a memory response that
//          arrived while decode was stalled. clear beats load.
// Ports  : clk, rst_n (async, active low), load, clear, d -> q, valid
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= d;
      r_valid <= 1'b1;
    end
  end

  assign q     = r_data;
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module : instruction_fetch_stage
// Purpose: Owns the PC and the IF/ID register. Issues ready-handshaked reads
//          to instruction memory, applies branch/jump redirects, parks one
//          response in a skid buffer under decode stall and inserts NOP
//          bubbles when no instruction is available.
// Ports  : clk, rst_n (async, active low), bus (instruction_fetch_stage_if
//          master modport)
// Config : BRANCH_DELAY_SLOT_EN - when defined, a redirect leaves IF/ID
//          untouched (delay slot proceeds); otherwise IF/ID is flushed.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_reset_pc_default,
  parameter logic [31:0] NOP_INSTR = c_nop_instr_default
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_stage_if.master bus
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_drain_addr;
  logic [31:0]  r_if_id_instruction;
  logic [31:0]  r_if_id_pcplus4;
  logic         r_if_id_valid;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_plus4;
  logic         w_skid_load;
  logic         w_skid_clear;
  logic [31:0]  w_skid_q;
  logic         w_skid_valid;

  assign w_redirect = bus.pcsrc | bus.jump;
  assign w_target   = redirect_target(bus.pcsrc, bus.branch_target,
                                      bus.jump_index, r_if_id_pcplus4[31:28]);
  assign w_pc_plus4 = r_pc + 32'd4;  // wraps modulo 2^32

  // Park the response only if it is not being thrown away by a redirect.
  assign w_skid_load  = (r_state == S_REQ) && bus.imem_ready && bus.stall && !w_redirect;
  assign w_skid_clear = w_redirect || ((r_state == S_HOLD) && !bus.stall);

  fetch_skid_buffer #(.WIDTH(32)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_skid_load),
    .clear (w_skid_clear),
    .d     (bus.imem_data),
    .q     (w_skid_q),
    .valid (w_skid_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET: w_next_state = S_REQ;
      S_REQ: begin
        if (w_redirect)
          // An unanswered request must complete before the new PC is issued.
          w_next_state = bus.imem_ready ? S_REQ : S_DRAIN;
        else if (bus.imem_ready && bus.stall)
          w_next_state = S_HOLD;
      end
      S_HOLD:  if (w_redirect || !bus.stall) w_next_state = S_REQ;
      S_DRAIN: if (bus.imem_ready) w_next_state = S_REQ;
      default: w_next_state = S_RESET;
    endcase
  end

  // Outputs: while draining, the address of the abandoned request is held.
  always_comb begin
    bus.imem_req  = (r_state == S_REQ) || (r_state == S_DRAIN);
    bus.imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  end

  // PC and IF/ID register. A bubble keeps PCPlus4 and only clears the word
  // and the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc                <= RESET_PC;
      r_drain_addr        <= RESET_PC;
      r_if_id_instruction <= NOP_INSTR;
      r_if_id_pcplus4     <= 32'd0;
      r_if_id_valid       <= 1'b0;
    end else if (w_redirect) begin
      r_pc <= w_target;
      if ((r_state == S_REQ) && !bus.imem_ready) r_drain_addr <= r_pc;
`ifdef BRANCH_DELAY_SLOT_EN
      // IF/ID holds the delay-slot instruction and is left alone.
`else
      r_if_id_instruction <= NOP_INSTR;
      r_if_id_valid       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.imem_ready) begin
            if (!bus.stall) begin
              r_if_id_instruction <= bus.imem_data;
              r_if_id_pcplus4     <= w_pc_plus4;
              r_if_id_valid       <= 1'b1;
              r_pc                <= w_pc_plus4;
            end
          end else if (!bus.stall) begin
            r_if_id_instruction <= NOP_INSTR;
            r_if_id_valid       <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            r_if_id_instruction <= w_skid_q;
            r_if_id_pcplus4     <= w_pc_plus4;
            r_if_id_valid       <= w_skid_valid;
            r_pc                <= w_pc_plus4;
          end
        end
        S_DRAIN: begin
          if (!bus.stall) begin
            r_if_id_instruction <= NOP_INSTR;
            r_if_id_valid       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc                = r_pc;
  assign bus.if_id_instruction = r_if_id_instruction;
  assign bus.if_id_pcplus4     = r_if_id_pcplus4;
  assign bus.if_id_valid       = r_if_id_valid;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none

module tb_instruction_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic ps, input logic [31:0] bt,
                       input logic jp, input logic [25:0] ji,
                       input logic rdy, input logic [31:0] dat);
    bus.stall = st; bus.pcsrc = ps; bus.branch_target = bt;
    bus.jump = jp; bus.jump_index = ji; bus.imem_ready = rdy; bus.imem_data = dat;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    n_tests++;
    if ({bus.imem_req, bus.pc, bus.imem_addr} !== {1'b0, 32'h0, 32'h0}) begin
      $display("FAIL reset_pc_req: got req=%b pc=%h addr=%h want 0/0/0", bus.imem_req, bus.pc, bus.imem_addr); n_fail++;
    end
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid} !== {32'h0, 32'h0, 1'b0}) begin
      $display("FAIL reset_ifid: got %h/%h/%b want 0/0/0", bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid); n_fail++;
    end
    rst_n = 1'b1;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      $display("FAIL reset_release_req: got %b want 0", bus.imem_req); n_fail++;
    end
    tick;
    n_tests++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL reset_first_req: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    tick;
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.pc} !== {32'h1234_5678, 32'h4, 1'b1, 32'h4}) begin
      $display("FAIL reset_first_fetch: got %h/%h/%b pc=%h want 12345678/4/1 pc=4", bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.pc); n_fail++;
    end
    // Asynchronous reset in the middle of a fetch.
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.imem_req, bus.pc, bus.if_id_valid, bus.imem_addr} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
      $display("FAIL reset_async: got req=%b pc=%h valid=%b addr=%h want 0/0/0/0", bus.imem_req, bus.pc, bus.if_id_valid, bus.imem_addr); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    rst_n = 1'b1;
    tick;
    n_tests++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL reset_rerelease: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); n_fail++;
    end
  endtask

  task automatic test_streaming;
    logic [31:0] words [3];
    words[0] = 32'h0022_1820; words[1] = 32'h0022_1822; words[2] = 32'h0022_1824;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, words[i]);
      tick;
      n_tests++;
      if ({bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.imem_req, bus.imem_addr} !==
          {words[i], 32'(4 * (i + 1)), 1'b1, 1'b1, 32'(4 * (i + 1))}) begin
        $display("FAIL stream_%0d: got %h/%h/%b req=%b addr=%h want %h/%h/1 req=1 addr=%h", i,
                 bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.imem_req, bus.imem_addr,
                 words[i], 32'(4 * (i + 1)), 32'(4 * (i + 1))); n_fail++;
      end
    end
  endtask

  task automatic test_stall;
    drive(1, 0, 0, 0, 0, 1, 32'h8C22_0004);
    for (int i = 0; i < 3; i++) begin
      tick;
      n_tests++;
      if ({bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.imem_req, bus.pc} !==
          {32'h0022_1824, 32'hC, 1'b1, 1'b0, 32'hC}) begin
        $display("FAIL stall_hold_%0d: got %h/%h/%b req=%b pc=%h want 00221824/c/1 req=0 pc=c", i,
                 bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.imem_req, bus.pc); n_fail++;
      end
      bus.imem_data = 32'hDEAD_BEEF;  // must be ignored while no request is out
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.imem_req, bus.imem_addr} !==
        {32'h8C22_0004, 32'h10, 1'b1, 1'b1, 32'h10}) begin
      $display("FAIL stall_release: got %h/%h/%b req=%b addr=%h want 8c220004/10/1 req=1 addr=10",
               bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.imem_req, bus.imem_addr); n_fail++;
    end
    tick;
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_valid, bus.imem_addr} !== {32'h0, 1'b0, 32'h10}) begin
      $display("FAIL stall_no_dup: got %h/%b addr=%h want 0/0 addr=10",
               bus.if_id_instruction, bus.if_id_valid, bus.imem_addr); n_fail++;
    end
  endtask

  task automatic test_branch;
    logic [31:0] exp_instr;
    logic        exp_valid;
`ifdef BRANCH_DELAY_SLOT_EN
    exp_instr = 32'h1111_1111; exp_valid = 1'b1;
`else
    exp_instr = 32'h0;         exp_valid = 1'b0;
`endif
    drive(0, 0, 0, 0, 0, 1, 32'h1111_1111);
    tick;
    drive(0, 1, 32'h0000_0041, 0, 0, 1, 32'h2222_2222);
    tick;
    n_tests++;
    if ({bus.pc, bus.imem_addr, bus.imem_req} !== {32'h40, 32'h40, 1'b1}) begin
      $display("FAIL branch_addr: got pc=%h addr=%h req=%b want 40/40/1", bus.pc, bus.imem_addr, bus.imem_req); n_fail++;
    end
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_valid} !== {exp_instr, exp_valid}) begin
      $display("FAIL branch_ifid: got %h/%b want %h/%b", bus.if_id_instruction, bus.if_id_valid, exp_instr, exp_valid); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 1, 32'h3333_3333);
    tick;
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid} !== {32'h3333_3333, 32'h44, 1'b1}) begin
      $display("FAIL branch_target_fetch: got %h/%h/%b want 33333333/44/1",
               bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid); n_fail++;
    end
  endtask

  task automatic test_redirect_drain;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    drive(0, 1, 32'h40, 0, 0, 0, 0);
    tick;
    n_tests++;
    if ({bus.imem_req, bus.imem_addr, bus.pc} !== {1'b1, 32'h44, 32'h40}) begin
      $display("FAIL drain_hold_addr: got req=%b addr=%h pc=%h want 1/44/40", bus.imem_req, bus.imem_addr, bus.pc); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    n_tests++;
    if ({bus.imem_addr, bus.if_id_valid} !== {32'h44, 1'b0}) begin
      $display("FAIL drain_wait: got addr=%h valid=%b want 44/0", bus.imem_addr, bus.if_id_valid); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 1, 32'hBADB_AD00);
    tick;
    n_tests++;
    if ({bus.imem_req, bus.imem_addr, bus.if_id_instruction, bus.if_id_valid} !== {1'b1, 32'h40, 32'h0, 1'b0}) begin
      $display("FAIL drain_discard: got req=%b addr=%h ifid=%h/%b want 1/40/0/0",
               bus.imem_req, bus.imem_addr, bus.if_id_instruction, bus.if_id_valid); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 1, 32'h4444_4444);
    tick;
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid} !== {32'h4444_4444, 32'h44, 1'b1}) begin
      $display("FAIL drain_new_fetch: got %h/%h/%b want 44444444/44/1",
               bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid); n_fail++;
    end
  endtask

  task automatic test_jump;
    drive(0, 1, 32'h1000_000C, 0, 0, 1, 32'hAAAA_AAAA);
    tick;
    drive(0, 0, 0, 0, 0, 1, 32'h5555_5555);
    tick;
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_pcplus4} !== {32'h5555_5555, 32'h1000_0010}) begin
      $display("FAIL jump_setup: got %h/%h want 55555555/10000010", bus.if_id_instruction, bus.if_id_pcplus4); n_fail++;
    end
    drive(0, 0, 0, 1, 26'd2, 1, 32'hAAAA_AAAA);
    tick;
    n_tests++;
    if ({bus.pc, bus.imem_addr} !== {32'h1000_0008, 32'h1000_0008}) begin
      $display("FAIL jump_target: got pc=%h addr=%h want 10000008/10000008", bus.pc, bus.imem_addr); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 1, 32'h6666_6666);
    tick;
    drive(0, 1, 32'h0000_0200, 1, 26'd2, 1, 32'hAAAA_AAAA);
    tick;
    n_tests++;
    if ({bus.pc, bus.imem_addr} !== {32'h200, 32'h200}) begin
      $display("FAIL jump_vs_branch: got pc=%h addr=%h want 200/200", bus.pc, bus.imem_addr); n_fail++;
    end
  endtask

  task automatic test_wrap;
    drive(0, 1, 32'hFFFF_FFFF, 0, 0, 1, 32'hAAAA_AAAA);
    tick;
    n_tests++;
    if ({bus.pc, bus.imem_addr} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
      $display("FAIL wrap_align: got pc=%h addr=%h want fffffffc/fffffffc", bus.pc, bus.imem_addr); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 1, 32'h7777_7777);
    tick;
    n_tests++;
    if ({bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.pc} !== {32'h7777_7777, 32'h0, 1'b1, 32'h0}) begin
      $display("FAIL wrap_pc: got %h/%h/%b pc=%h want 77777777/0/1 pc=0",
               bus.if_id_instruction, bus.if_id_pcplus4, bus.if_id_valid, bus.pc); n_fail++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_stall;
    test_branch;
    test_redirect_drain;
    test_jump;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
